// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module  : serial_sub_pkg
// Purpose : Shared types and constants for the bit-serial subtractor.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    // Default operand width in bits
    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/serial_sub_ctrl_fs_bit_cell.sv
// ============================================================================
// Module  : fs_bit_cell
// Purpose : Combinational 1-bit full subtractor (x - y - bi).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference and borrow-out of a single bit position
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & (y ^ bi)) | (y & bi);
    end

endmodule : fs_bit_cell

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module  : serial_sub_ctrl
// Purpose : Bit-serial subtractor controller. Computes a - b - bin over
//           WIDTH cycles, LSB first, through one fs_bit_cell.
// Options : define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // One extra bit so the counter can reach WIDTH without wrapping
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              brw_q, brw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cell_d;
    logic              cell_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // The only arithmetic element: current LSBs plus the registered borrow
    fs_bit_cell u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath control; everything holds unless updated
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    diff_d  = '0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift right so the next bit reaches position 0;
                // result bits enter at the top and settle into place.
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                brw_d  = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit a_q[0]/b_q[0] hold the operand MSBs
                    // and cell_d is the result MSB.
                    ovf_d = (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        diff = diff_q;
        bout = brw_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule : serial_sub_ctrl

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// Module  : tb_serial_sub_ctrl
// Purpose : Self-checking bench for serial_sub_ctrl (WIDTH = 8).
//           Honours SERIAL_SUB_OVF_EN for the optional ovf output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    wire          busy;
    wire          done;
    wire  [W-1:0] diff;
    wire          bout;
`ifdef SERIAL_SUB_OVF_EN
    wire          ovf;
`else
    wire          ovf = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: a - b - bin in plain integer arithmetic
    function automatic logic [W:0] ref_sub(input logic [W-1:0] ia, ib, input logic ibin);
        int r;
        r = int'(ia) - int'(ib) - int'(ibin);
        ref_sub = {(r < 0), W'(r)};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] ia, ib, input logic [W-1:0] id);
        ref_ovf = (ia[W-1] != ib[W-1]) && (id[W-1] != ia[W-1]);
    endfunction

    // Issue one operation from IDLE; lat counts edges including the accept edge
    task automatic run_op(input logic [W-1:0] ia, ib, input logic ibin, output int lat);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, diff, bout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'h05, 8'h03, 1'b0, lat);
        n_tests++;
        if (lat != W + 1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges (done=%b), want %0d", lat, done, W + 1);
        end
        n_tests++;
        if (diff !== 8'h02 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%h bout=%b, want 02/0", diff, bout);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h02) begin
            n_fail++;
            $display("FAIL basic_pulse: got done=%b busy=%b diff=%h, want 0/0/02", done, busy, diff);
        end
    endtask

    task automatic test_borrow();
        int lat;
        run_op(8'h00, 8'h01, 1'b0, lat);
        n_tests++;
        if (done !== 1'b1 || diff !== 8'hFF || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_b: got done=%b diff=%h bout=%b, want 1/FF/1", done, diff, bout);
        end
        run_op(8'h00, 8'h00, 1'b1, lat);
        n_tests++;
        if (done !== 1'b1 || diff !== 8'hFF || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_bin: got done=%b diff=%h bout=%b, want 1/FF/1", done, diff, bout);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int cyc = 0;
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        // Keep start high through RUN and the DONE cycle
        while (ndone == 0 && cyc < 20) begin
            if (done === 1'b1) ndone++;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_tests++;
        if (ndone != 1 || diff !== 8'h2D) begin
            n_fail++;
            $display("FAIL ignore_start_result: got dones=%0d diff=%h, want 1/2D", ndone, diff);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone != 1 || diff !== 8'h2D) begin
            n_fail++;
            $display("FAIL ignore_start_no_second: got activity=%0d diff=%h, want 1/2D", ndone, diff);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen = 0;
        @(negedge clk);
        a = 8'hA5; b = 8'h13; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, diff, bout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
        end
        run_op(8'h0A, 8'h0A, 1'b0, lat);
        n_tests++;
        if (done !== 1'b1 || diff !== 8'h00 || bout !== 1'b0 || lat != W + 1) begin
            n_fail++;
            $display("FAIL abort_recover: got done=%b diff=%h bout=%b lat=%0d, want 1/00/0/%0d",
                     done, diff, bout, lat, W + 1);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int lat;
        run_op(8'h80, 8'h01, 1'b0, lat);
        n_tests++;
        if (diff !== 8'h7F || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got diff=%h ovf=%b, want 7F/1", diff, ovf);
        end
        @(negedge clk);
        n_tests++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: got ovf=%b, want 1", ovf);
        end
        run_op(8'h10, 8'h01, 1'b0, lat);
        n_tests++;
        if (diff !== 8'h0F || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got diff=%h ovf=%b, want 0F/0", diff, ovf);
        end
    endtask
`endif

    task automatic test_random();
        int lat;
        logic [W-1:0] ra, rb;
        logic rbin;
        logic [W:0] exp;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            exp = ref_sub(ra, rb, rbin);
            run_op(ra, rb, rbin, lat);
            n_tests++;
            if (done !== 1'b1 || diff !== exp[W-1:0] || bout !== exp[W]) begin
                n_fail++;
                $display("FAIL random_%0d: %h-%h-%b got done=%b diff=%h bout=%b, want diff=%h bout=%b",
                         i, ra, rb, rbin, done, diff, bout, exp[W-1:0], exp[W]);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_tests++;
            if (ovf !== ref_ovf(ra, rb, exp[W-1:0])) begin
                n_fail++;
                $display("FAIL random_ovf_%0d: %h-%h-%b got ovf=%b, want %b",
                         i, ra, rb, rbin, ovf, ref_ovf(ra, rb, exp[W-1:0]));
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int stamps[$];
        int gap;
        @(negedge clk);
        a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) stamps.push_back(c);
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++;
        if (stamps.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", stamps.size());
        end
        for (int k = 1; k < stamps.size(); k++) begin
            gap = stamps[k] - stamps[k-1];
            n_tests++;
            if (gap != W + 2) begin
                n_fail++;
                $display("FAIL b2b_gap_%0d: got %0d cycles, want %0d", k, gap, W + 2);
            end
        end
        n_tests++;
        if (diff !== 8'h33 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: got diff=%h bout=%b, want 33/0", diff, bout);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_sub_ctrl

`default_nettype wire
